// File: rtl/count_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : count_sequencer_if
// Description : Config handshake, run control and status bundle for the
//               count_sequencer run-control block. The pause signal exists
//               only when CNT_SEQ_PAUSE_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
interface count_sequencer_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [WIDTH-1:0]      cfg_limit;
    logic [PRESCALE_W-1:0] cfg_div;
    logic                  cfg_periodic;
    logic                  start;
    logic                  stop;
`ifdef CNT_SEQ_PAUSE_EN
    logic                  pause;
`endif
    logic [WIDTH-1:0]      count;
    logic                  tick;
    logic                  running;
    logic                  done;

    modport master (
`ifdef CNT_SEQ_PAUSE_EN
        output pause,
`endif
        output cfg_valid, cfg_limit, cfg_div, cfg_periodic, start, stop,
        input  cfg_ready, count, tick, running, done
    );

    modport slave (
`ifdef CNT_SEQ_PAUSE_EN
        input  pause,
`endif
        input  cfg_valid, cfg_limit, cfg_div, cfg_periodic, start, stop,
        output cfg_ready, count, tick, running, done
    );
endinterface
`default_nettype wire

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : count_sequencer
// Description : Prescaled start/stop run-control sequencer for an event
//               counter with terminal-count tick, one-shot or periodic mode.
//               Optional pause input enabled by defining CNT_SEQ_PAUSE_EN.
// Revision    : 1.0  initial release
// ============================================================================
module count_sequencer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  wire                clk,
    input  wire                rst,
    count_sequencer_if.slave   bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,
        ST_RUN  = c_st_run,
        ST_DONE = c_st_done
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_count;
    logic [PRESCALE_W-1:0] r_presc;
    logic [WIDTH-1:0]      r_limit;
    logic [PRESCALE_W-1:0] r_div;
    logic                  r_periodic;
    logic                  r_tick;
    logic                  r_running;
    logic                  r_done;
    logic                  r_cfg_ready;

    state_t                w_state;
    logic [WIDTH-1:0]      w_count;
    logic [PRESCALE_W-1:0] w_presc;
    logic [WIDTH-1:0]      w_limit;
    logic [PRESCALE_W-1:0] w_div;
    logic                  w_periodic;
    logic                  w_tick;
    logic                  w_cfg_fire;
    logic                  w_pause;

`ifdef CNT_SEQ_PAUSE_EN
    assign w_pause = bus.pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_cfg_fire = bus.cfg_valid & r_cfg_ready;

    // Next-state and datapath; stop outranks any step in the same cycle.
    always_comb begin
        w_state    = r_state;
        w_count    = r_count;
        w_presc    = r_presc;
        w_limit    = r_limit;
        w_div      = r_div;
        w_periodic = r_periodic;
        w_tick     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_cfg_fire) begin
                    w_limit    = bus.cfg_limit;
                    w_div      = bus.cfg_div;
                    w_periodic = bus.cfg_periodic;
                    w_count    = '0;
                    w_state    = ST_IDLE;
                end else if (bus.start) begin
                    w_state = ST_RUN;
                    w_count = '0;
                    w_presc = '0;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    w_state = ST_IDLE;
                    w_presc = '0;
                end else if (!w_pause) begin
                    if (r_presc == r_div) begin
                        w_presc = '0;
                        if (r_count == r_limit) begin
                            w_tick = 1'b1;
                            if (r_periodic) begin
                                w_count = '0;
                            end else begin
                                w_state = ST_DONE;
                            end
                        end else begin
                            w_count = r_count + WIDTH'(1);
                        end
                    end else begin
                        w_presc = r_presc + PRESCALE_W'(1);
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_count = '0;
                w_presc = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_presc     <= '0;
            r_limit     <= '1;
            r_div       <= '0;
            r_periodic  <= 1'b0;
            r_tick      <= 1'b0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_count     <= w_count;
            r_presc     <= w_presc;
            r_limit     <= w_limit;
            r_div       <= w_div;
            r_periodic  <= w_periodic;
            r_tick      <= w_tick;
            r_running   <= (w_state == ST_RUN);
            r_done      <= (w_state == ST_DONE);
            r_cfg_ready <= (w_state != ST_RUN);
        end
    end

    assign bus.count     = r_count;
    assign bus.tick      = r_tick;
    assign bus.running   = r_running;
    assign bus.done      = r_done;
    assign bus.cfg_ready = r_cfg_ready;

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_sequencer
// Description : Directed scoreboard bench for count_sequencer; per-cycle
//               expected status is queued by stimulus and popped by a monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_count_sequencer;

    typedef struct packed {
        logic [7:0] count;
        logic       tick;
        logic       running;
        logic       done;
        logic       cfg_ready;
    } status_t;

    logic    clk;
    logic    rst;
    int      n_checks;
    int      n_errors;
    status_t exp_q[$];
    string   name_q[$];
    status_t mon_exp;
    string   mon_name;

    count_sequencer_if #(.WIDTH(8), .PRESCALE_W(4)) bus_if ();

    count_sequencer #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic status_t cur_status();
        status_t s;
        s.count     = bus_if.count;
        s.tick      = bus_if.tick;
        s.running   = bus_if.running;
        s.done      = bus_if.done;
        s.cfg_ready = bus_if.cfg_ready;
        return s;
    endfunction

    task automatic check_status(input string nm, input status_t act, input status_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got count=%0d tick=%b run=%b done=%b rdy=%b, expected count=%0d tick=%b run=%b done=%b rdy=%b",
                     nm, act.count, act.tick, act.running, act.done, act.cfg_ready,
                     exp.count, exp.tick, exp.running, exp.done, exp.cfg_ready);
        end
    endtask

    // Monitor: every posedge with an outstanding expectation is compared.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            check_status(mon_name, cur_status(), mon_exp);
        end
    end

    task automatic set_cfg(input logic [7:0] lim, input logic [3:0] dv, input logic per);
        bus_if.cfg_limit    = lim;
        bus_if.cfg_div      = dv;
        bus_if.cfg_periodic = per;
    endtask

    // Drive one cycle of inputs and queue the status expected after the next edge.
    task automatic cyc(input logic cv, input logic st, input logic sp,
                       input logic [7:0] c, input logic t, input logic r,
                       input logic d, input logic y, input string nm);
        status_t e;
        bus_if.cfg_valid = cv;
        bus_if.start     = st;
        bus_if.stop      = sp;
        e.count     = c;
        e.tick      = t;
        e.running   = r;
        e.done      = d;
        e.cfg_ready = y;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running, required finished");
        $fatal(1, "timeout");
    end

    initial begin
        status_t rs;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.cfg_valid = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.stop      = 1'b0;
`ifdef CNT_SEQ_PAUSE_EN
        bus_if.pause     = 1'b0;
`endif
        set_cfg(8'd0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rs = '{count: 8'd0, tick: 1'b0, running: 1'b0, done: 1'b0, cfg_ready: 1'b1};
        check_status("reset", cur_status(), rs);
        rst = 1'b0;

        // One-shot, limit 3, div 0; start held in RUN is ignored
        set_cfg(8'd3, 4'd0, 1'b0);
        cyc(1, 0, 0, 8'd0, 0, 0, 0, 1, "A_cfg");
        cyc(0, 1, 0, 8'd0, 0, 1, 0, 0, "A_start");
        cyc(0, 1, 0, 8'd1, 0, 1, 0, 0, "A_c1");
        cyc(0, 1, 0, 8'd2, 0, 1, 0, 0, "A_c2");
        cyc(0, 0, 0, 8'd3, 0, 1, 0, 0, "A_c3");
        cyc(0, 0, 0, 8'd3, 1, 0, 1, 1, "A_term");
        cyc(0, 0, 1, 8'd3, 0, 0, 1, 1, "A_done_hold");

        // Periodic, limit 2, div 1: count 0,1,1,2,2,0 with tick every 6
        set_cfg(8'd2, 4'd1, 1'b1);
        cyc(1, 0, 0, 8'd0, 0, 0, 0, 1, "B_cfg");
        cyc(0, 1, 0, 8'd0, 0, 1, 0, 0, "B_start");
        for (int i = 1; i <= 14; i++) begin
            cyc(0, 0, 0, 8'((i / 2) % 3), (i % 6) == 0, 1, 0, 0, "B_run");
        end

        // stop+start in RUN -> IDLE with count held; cfg beats start in IDLE
        cyc(0, 1, 1, 8'd1, 0, 0, 0, 1, "C_stop_start");
        cyc(0, 0, 0, 8'd1, 0, 0, 0, 1, "C_idle_hold");
        set_cfg(8'd1, 4'd0, 1'b0);
        cyc(1, 1, 0, 8'd0, 0, 0, 0, 1, "C_cfg_over_start");
        cyc(0, 1, 0, 8'd0, 0, 1, 0, 0, "C_start");
        cyc(0, 0, 0, 8'd1, 0, 1, 0, 0, "C_c1");
        cyc(0, 0, 0, 8'd1, 1, 0, 1, 1, "C_term");

        // cfg held during RUN is not latched until after stop
        set_cfg(8'd5, 4'd0, 1'b1);
        cyc(1, 0, 0, 8'd0, 0, 0, 0, 1, "D_cfg");
        cyc(0, 1, 0, 8'd0, 0, 1, 0, 0, "D_start");
        set_cfg(8'd2, 4'd0, 1'b1);
        cyc(1, 0, 0, 8'd1, 0, 1, 0, 0, "D_busy1");
        cyc(1, 0, 0, 8'd2, 0, 1, 0, 0, "D_busy2");
        cyc(1, 0, 0, 8'd3, 0, 1, 0, 0, "D_busy3");
        cyc(1, 0, 1, 8'd3, 0, 0, 0, 1, "D_stop");
        cyc(1, 0, 0, 8'd0, 0, 0, 0, 1, "D_cfg_after_stop");
        cyc(0, 1, 0, 8'd0, 0, 1, 0, 0, "D_start2");
        cyc(0, 0, 0, 8'd1, 0, 1, 0, 0, "D_c1");
        cyc(0, 0, 0, 8'd2, 0, 1, 0, 0, "D_c2");
        cyc(0, 0, 0, 8'd0, 1, 1, 0, 0, "D_wrap");
        cyc(0, 0, 0, 8'd1, 0, 1, 0, 0, "D_c1b");
        cyc(0, 0, 0, 8'd2, 0, 1, 0, 0, "D_c2b");
        cyc(0, 0, 1, 8'd2, 0, 0, 0, 1, "D_stop_at_term");

`ifdef CNT_SEQ_PAUSE_EN
        // Pause for 5 cycles delays the next tick by exactly 5 cycles
        set_cfg(8'd3, 4'd0, 1'b1);
        cyc(1, 0, 0, 8'd0, 0, 0, 0, 1, "E_cfg");
        cyc(0, 1, 0, 8'd0, 0, 1, 0, 0, "E_start");
        cyc(0, 0, 0, 8'd1, 0, 1, 0, 0, "E_c1");
        cyc(0, 0, 0, 8'd2, 0, 1, 0, 0, "E_c2");
        cyc(0, 0, 0, 8'd3, 0, 1, 0, 0, "E_c3");
        cyc(0, 0, 0, 8'd0, 1, 1, 0, 0, "E_wrap");
        cyc(0, 0, 0, 8'd1, 0, 1, 0, 0, "E_c1b");
        bus_if.pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 8'd1, 0, 1, 0, 0, "E_paused");
        end
        bus_if.pause = 1'b0;
        cyc(0, 0, 0, 8'd2, 0, 1, 0, 0, "E_c2b");
        cyc(0, 0, 0, 8'd3, 0, 1, 0, 0, "E_c3b");
        cyc(0, 0, 0, 8'd0, 1, 1, 0, 0, "E_wrap_late");
        cyc(0, 0, 1, 8'd0, 0, 0, 0, 1, "E_stop");
`endif

        // Asynchronous reset mid-RUN at count 5
        set_cfg(8'd7, 4'd0, 1'b0);
        cyc(1, 0, 0, 8'd0, 0, 0, 0, 1, "F_cfg");
        cyc(0, 1, 0, 8'd0, 0, 1, 0, 0, "F_start");
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 8'(i), 0, 1, 0, 0, "F_run");
        end
        rst = 1'b1;
        #1;
        rs = '{count: 8'd0, tick: 1'b0, running: 1'b0, done: 1'b0, cfg_ready: 1'b1};
        check_status("F_async_rst", cur_status(), rs);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc(0, 0, 0, 8'd0, 0, 0, 0, 1, "F_post_rst");
        cyc(0, 1, 0, 8'd0, 0, 1, 0, 0, "F_restart");
        cyc(0, 0, 0, 8'd1, 0, 1, 0, 0, "F_div_reset");
        cyc(0, 0, 1, 8'd1, 0, 0, 0, 1, "F_stop");

        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
